// File: rtl/iir_pkg.sv
// iir_pkg: shared defaults, coefficient address map, FSM states and width helpers
package iir_pkg;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int FRAC = 8;
  localparam int ORDER = 2;
  localparam int CHANNELS = 2;
  localparam int DEPTH = 32;
  localparam int B_BASE = 0;
  localparam int A_BASE = ORDER + 1;
  typedef enum logic [2:0] {IDLE, INIT, MAC, WB, DONE} state_t;
  function automatic int acc_w(int dw, int cw, int order);
    return dw + cw + $clog2(2 * order + 1);
  endfunction
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic below(int idx, int lim);
    return idx < lim;
  endfunction
endpackage

// File: rtl/iir_if.sv
// iir_if: register-shim side of the IIR core (coefficient/sample writes, output reads, run control)
interface iir_if import iir_pkg::*; #(
  parameter int DW = iir_pkg::DW,
  parameter int CW = iir_pkg::CW,
  parameter int ORDER = iir_pkg::ORDER,
  parameter int CHANNELS = iir_pkg::CHANNELS,
  parameter int DEPTH = iir_pkg::DEPTH
);
  localparam int KW = idx_w(2 * ORDER + 1);
  localparam int CHW = idx_w(CHANNELS);
  localparam int AW = idx_w(DEPTH);
  logic coef_we_i;
  logic [KW-1:0] coef_addr_i;
  logic [CW-1:0] coef_data_i;
  logic in_we_i;
  logic [CHW-1:0] in_ch_i;
  logic [AW-1:0] in_addr_i;
  logic [DW-1:0] in_data_i;
  logic [CHW-1:0] out_ch_i;
  logic [AW-1:0] out_addr_i;
  logic [DW-1:0] out_data_o;
  logic start_i;
  logic busy_o;
  logic done_o;
  logic sat_o;
  modport master (
    output coef_we_i, coef_addr_i, coef_data_i, in_we_i, in_ch_i, in_addr_i, in_data_i,
    output out_ch_i, out_addr_i, start_i,
    input out_data_o, busy_o, done_o, sat_o
  );
  modport slave (
    input coef_we_i, coef_addr_i, coef_data_i, in_we_i, in_ch_i, in_addr_i, in_data_i,
    input out_ch_i, out_addr_i, start_i,
    output out_data_o, busy_o, done_o, sat_o
  );
endinterface

// File: rtl/iir_mac.sv
// iir_mac: signed multiply-accumulate with clear, final arithmetic shift and saturation
module iir_mac import iir_pkg::*; #(
  parameter int DW = iir_pkg::DW,
  parameter int CW = iir_pkg::CW,
  parameter int FRAC = iir_pkg::FRAC,
  parameter int ORDER = iir_pkg::ORDER
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  input  logic sub,
  input  logic signed [DW-1:0] s,
  input  logic signed [CW-1:0] c,
  output logic [DW-1:0] y,
  output logic sat
);
  localparam int AW = acc_w(DW, CW, ORDER);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [AW-1:0] acc, sh;
  logic signed [DW+CW-1:0] p;
  logic hi, lo;
  assign p = s * c;
  assign sh = acc >>> FRAC;
  assign hi = sh > MAXV;
  assign lo = sh < MINV;
  assign sat = hi || lo;
  assign y = hi ? MAXV[DW-1:0] : lo ? MINV[DW-1:0] : sh[DW-1:0];
  // One signed product per enabled cycle, a-terms subtracted; cleared between samples
  always_ff @(posedge clk_i)
    if (rst_i || clr) acc <= '0;
    else if (en) acc <= sub ? acc - AW'(p) : acc + AW'(p);
endmodule

// File: rtl/iir_buffered_core.sv
// iir_buffered_core: multi-channel direct-form-I IIR filter run as a single sequential MAC engine
module iir_buffered_core import iir_pkg::*; #(
  parameter int DW = iir_pkg::DW,
  parameter int CW = iir_pkg::CW,
  parameter int FRAC = iir_pkg::FRAC,
  parameter int ORDER = iir_pkg::ORDER,
  parameter int CHANNELS = iir_pkg::CHANNELS,
  parameter int DEPTH = iir_pkg::DEPTH
) (
  input logic clk_i,
  input logic rst_i,
  iir_if.slave bus
);
  localparam int TAPS = 2 * ORDER + 1;
  localparam int KW = idx_w(TAPS);
  localparam int CHW = idx_w(CHANNELS);
  localparam int AW = idx_w(DEPTH);
  localparam int AB = ORDER + 1;
  state_t state, state_n;
  logic [CHW-1:0] ch;
  logic [AW-1:0] n;
  logic [KW-1:0] k;
  logic signed [CW-1:0] coef [TAPS];
  logic signed [DW-1:0] xh [ORDER];
  logic signed [DW-1:0] yh [ORDER];
  logic [DW-1:0] in_buf [CHANNELS][DEPTH];
  logic [DW-1:0] out_buf [CHANNELS][DEPTH];
  logic signed [DW-1:0] x_cur, s;
  logic signed [CW-1:0] c;
  logic [DW-1:0] y;
  logic sub, mac_sat, sat, busy, last_tap, last_n, last_ch, coef_ok, in_ok, rd_ok;
  assign busy = state == INIT || state == MAC || state == WB;
  assign bus.busy_o = busy;
  assign bus.done_o = state == DONE;
  assign bus.sat_o = sat;
  assign last_tap = k == KW'(TAPS - 1);
  assign last_n = n == AW'(DEPTH - 1);
  assign last_ch = ch == CHW'(CHANNELS - 1);
  assign coef_ok = !busy && bus.coef_we_i && below(int'(bus.coef_addr_i), TAPS);
  assign in_ok = !busy && bus.in_we_i && below(int'(bus.in_ch_i), CHANNELS) && below(int'(bus.in_addr_i), DEPTH);
  assign rd_ok = below(int'(bus.out_ch_i), CHANNELS) && below(int'(bus.out_addr_i), DEPTH);
  assign x_cur = in_buf[ch][n];
  // State register
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  // Next state: a run request is honoured only outside a run
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = bus.start_i ? INIT : state;
      INIT: state_n = MAC;
      MAC: state_n = last_tap ? WB : MAC;
      WB: state_n = last_n && last_ch ? DONE : MAC;
      default: state_n = IDLE;
    endcase
  end
  // Tap select: tap 0 is the current input, then x history, then y history (subtracted)
  always_comb begin
    s = x_cur;
    c = coef[k];
    sub = 1'b0;
    for (int i = 0; i < ORDER; i++) begin
      if (int'(k) == B_BASE + i + 1) s = xh[i];
      if (int'(k) == AB + i) begin
        s = yh[i];
        sub = 1'b1;
      end
    end
  end
  // Counters, history shift and sticky saturation; history restarts with each channel
  always_ff @(posedge clk_i)
    if (rst_i || state == INIT) begin
      ch <= '0;
      n <= '0;
      k <= '0;
      sat <= 1'b0;
      xh <= '{default: '0};
      yh <= '{default: '0};
    end else if (state == MAC) begin
      k <= last_tap ? '0 : k + 1'b1;
    end else if (state == WB) begin
      sat <= sat | mac_sat;
      n <= last_n ? '0 : n + 1'b1;
      ch <= last_n ? ch + 1'b1 : ch;
      for (int i = ORDER - 1; i > 0; i--) begin
        xh[i] <= last_n ? '0 : xh[i-1];
        yh[i] <= last_n ? '0 : yh[i-1];
      end
      xh[0] <= last_n ? '0 : x_cur;
      yh[0] <= last_n ? '0 : y;
    end
  // Sample buffers: host writes while idle, filter results at write-back
  always_ff @(posedge clk_i) begin
    if (in_ok) in_buf[bus.in_ch_i][bus.in_addr_i] <= bus.in_data_i;
    if (state == WB) out_buf[ch][n] <= y;
  end
  // Shared coefficient bank
  always_ff @(posedge clk_i)
    if (rst_i) coef <= '{default: '0};
    else if (coef_ok) coef[bus.coef_addr_i] <= bus.coef_data_i;
  // Registered output read, zero for out-of-range indices
  always_ff @(posedge clk_i)
    bus.out_data_o <= rst_i ? '0 : rd_ok ? out_buf[bus.out_ch_i][bus.out_addr_i] : '0;
  iir_mac #(.DW(DW), .CW(CW), .FRAC(FRAC), .ORDER(ORDER)) u_mac (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr(state != MAC),
    .en(state == MAC),
    .sub(sub),
    .s(s),
    .c(c),
    .y(y),
    .sat(mac_sat)
  );
endmodule

// File: tb/tb_iir_buffered_core.sv
// tb_iir_buffered_core: directed and randomized checks against a behavioural IIR model
module tb_iir_buffered_core;
  import iir_pkg::*;
  localparam int TAPS = 2 * ORDER + 1;
  localparam int KW = idx_w(TAPS);
  localparam int RUN_CYC = 1 + CHANNELS * DEPTH * (2 * ORDER + 2);
  localparam longint YMAX = 64'sd2147483647;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  longint m_coef [TAPS];
  longint mx [CHANNELS][DEPTH];
  longint my [CHANNELS][DEPTH];
  logic m_sat;
  iir_if bus ();
  iir_buffered_core dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint rnd(input int bits);
    return longint'($signed($urandom)) >>> (32 - bits);
  endfunction

  task automatic write_coef(input int a, input longint v);
    bus.coef_we_i = 1'b1;
    bus.coef_addr_i = KW'(a);
    bus.coef_data_i = 16'(v);
    tick();
    bus.coef_we_i = 1'b0;
    if (a < TAPS) m_coef[a] = v;
  endtask

  task automatic write_in(input int c, input int a, input longint v);
    bus.in_we_i = 1'b1;
    bus.in_ch_i = 1'(c);
    bus.in_addr_i = 5'(a);
    bus.in_data_i = 32'(v);
    tick();
    bus.in_we_i = 1'b0;
    mx[c][a] = v;
  endtask

  task automatic rd(input int c, input int a, output logic [31:0] v);
    bus.out_ch_i = 1'(c);
    bus.out_addr_i = 5'(a);
    tick();
    v = bus.out_data_o;
  endtask

  // y[n] = sat((sum b_k x[n-k] - sum a_k y[n-k]) >>> FRAC), history zero per channel
  task automatic model_run();
    m_sat = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      for (int n = 0; n < DEPTH; n++) begin
        longint acc, r;
        acc = 0;
        for (int j = 0; j <= ORDER; j++) if (n >= j) acc += m_coef[B_BASE + j] * mx[c][n - j];
        for (int j = 1; j <= ORDER; j++) if (n >= j) acc -= m_coef[A_BASE + j - 1] * my[c][n - j];
        r = acc >>> FRAC;
        if (r > YMAX) begin r = YMAX; m_sat = 1'b1; end
        if (r < -YMAX - 1) begin r = -YMAX - 1; m_sat = 1'b1; end
        my[c][n] = r;
      end
  endtask

  task automatic check_out(input string tag);
    logic [31:0] v;
    for (int c = 0; c < CHANNELS; c++)
      for (int n = 0; n < DEPTH; n++) begin
        rd(c, n, v);
        check($sformatf("%s_y%0d_%0d", tag, c, n), v, 32'(my[c][n]));
      end
  endtask

  task automatic run(input string tag, input int wch = -1, input int wa = 0, input longint wv = 0,
                     input bit poke = 1'b0, input int abort_at = -1);
    int cyc = 0;
    if (wch >= 0) begin
      bus.in_we_i = 1'b1;
      bus.in_ch_i = 1'(wch);
      bus.in_addr_i = 5'(wa);
      bus.in_data_i = 32'(wv);
      mx[wch][wa] = wv;
    end
    model_run();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.in_we_i = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    while (!bus.done_o && cyc < 2000) begin
      if (abort_at == cyc) begin
        rst = 1'b1;
        tick();
        check({tag, "_rst_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_rst_done"}, 32'(bus.done_o), 32'd0);
        rst = 1'b0;
        for (int j = 0; j < TAPS; j++) m_coef[j] = 0;
        return;
      end
      if (poke && cyc == 50) begin
        bus.start_i = 1'b1;
        bus.in_we_i = 1'b1;
        bus.in_ch_i = 1'b0;
        bus.in_addr_i = 5'd0;
        bus.in_data_i = ~32'(mx[0][0]);
        bus.coef_we_i = 1'b1;
        bus.coef_addr_i = KW'(B_BASE);
        bus.coef_data_i = ~16'(m_coef[B_BASE]);
      end
      tick();
      cyc++;
      bus.start_i = 1'b0;
      bus.in_we_i = 1'b0;
      bus.coef_we_i = 1'b0;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(RUN_CYC));
    check({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_sat"}, 32'(bus.sat_o), 32'(m_sat));
    check_out(tag);
  endtask

  initial begin
    logic [31:0] v;
    bus.coef_we_i = 1'b0;
    bus.coef_addr_i = '0;
    bus.coef_data_i = '0;
    bus.in_we_i = 1'b0;
    bus.in_ch_i = '0;
    bus.in_addr_i = '0;
    bus.in_data_i = '0;
    bus.out_ch_i = '0;
    bus.out_addr_i = '0;
    bus.start_i = 1'b0;
    for (int j = 0; j < TAPS; j++) m_coef[j] = 0;
    repeat (3) tick();
    check("rst_out", bus.out_data_o, 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_sat", 32'(bus.sat_o), 32'd0);
    rst = 1'b0;
    tick();
    write_coef(B_BASE, 256);
    write_coef(7, 1234);
    for (int i = 0; i < DEPTH; i++) begin
      write_in(0, i, 4 * i);
      write_in(1, i, rnd(32));
    end
    run("pass");
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, i, v);
      check("pass_spec", v, 32'(4 * i));
    end
    write_coef(B_BASE, 128);
    write_coef(A_BASE, -128);
    for (int i = 0; i < DEPTH; i++) begin
      write_in(0, i, i == 0 ? 256 : 0);
      write_in(1, i, 0);
    end
    run("pole");
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, i, v);
      check("pole_spec", v, i < 8 ? 32'(128 >> i) : 32'd0);
    end
    write_coef(B_BASE, 32767);
    write_coef(A_BASE, 0);
    write_in(0, 0, 64'sh7fffffff);
    run("sat");
    rd(0, 0, v);
    check("sat_y0", v, 32'h7fffffff);
    check("sat_flag", 32'(bus.sat_o), 32'd1);
    write_coef(B_BASE, 128);
    write_in(0, 0, -1);
    run("neg1");
    rd(0, 0, v);
    check("neg1_y0", v, 32'hffffffff);
    check("neg1_sat_cleared", 32'(bus.sat_o), 32'd0);
    write_in(0, 0, -512);
    run("neg2");
    rd(0, 0, v);
    check("neg2_y0", v, 32'hffffff00);
    write_coef(A_BASE, -128);
    for (int i = 0; i < DEPTH; i++) write_in(0, i, 1000);
    run("indep");
    for (int j = 0; j < TAPS; j++) write_coef(j, j < A_BASE ? rnd(10) : rnd(8));
    for (int i = 0; i < DEPTH; i++) begin
      write_in(0, i, rnd(20));
      write_in(1, i, rnd(20));
    end
    run("busy", -1, 0, 0, 1'b1);
    run("abort", -1, 0, 0, 1'b0, 100);
    for (int j = 0; j < TAPS; j++) write_coef(j, j < A_BASE ? rnd(10) : rnd(8));
    run("after");
    for (int it = 0; it < 3; it++) begin
      for (int j = 0; j < TAPS; j++) write_coef(j, j < A_BASE ? rnd(12) : rnd(9));
      for (int i = 0; i < DEPTH; i++) begin
        write_in(0, i, rnd(it == 2 ? 32 : 20));
        write_in(1, i, rnd(it == 2 ? 32 : 20));
      end
      run($sformatf("rand%0d", it), 1, DEPTH - 1, rnd(20));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
